// File: rtl/avalon_onchip_ram_dp.sv
// ---------------------------------------------------------------------------
// avalon_onchip_ram_dp
//   True dual-port on-chip RAM exposed as two independent Avalon-MM slaves
//   (s1, s2). Both ports can read or write any word in any cycle. There is no
//   waitrequest. Reads return through a READ_LATENCY-deep valid/data pipeline
//   that is qualified by readdatavalid.
//
// Ports
//   clk                 sole clock; all logic is rising-edge
//   reset               synchronous active-high; flushes the read pipelines
//   reset_req           stall request; freezes the block like clken=0
//   clken               global clock enable
//   sN_address          word address (N = 1, 2)
//   sN_chipselect       slave select
//   sN_read/sN_write    request strobes; write wins if both are asserted
//   sN_byteenable       byte lane enables for writes
//   sN_writedata        write data
//   sN_readdata         read data of the beat leaving the pipeline
//   sN_readdatavalid    qualifies sN_readdata
//
// Behaviour notes
//   - Cross-port read of an address written in the same cycle returns the
//     old contents.
//   - When both ports write the same word, s1 wins on the lanes that both
//     ports enable.
//   - Addresses >= DEPTH drop writes and read back as zero.
//   - Reset does not touch memory contents.
// ---------------------------------------------------------------------------
module avalon_onchip_ram_dp #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 40000,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "ram.hex"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_req,
  input  logic                      clken,

  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
  input  logic [DATA_WIDTH-1:0]     s1_writedata,
  output logic [DATA_WIDTH-1:0]     s1_readdata,
  output logic                      s1_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]     s2_address,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0]     s2_writedata,
  output logic [DATA_WIDTH-1:0]     s2_readdata,
  output logic                      s2_readdatavalid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Power-up image of the memory array; contents are never cleared later.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  logic                  w_ce;

  // Port views as 2-entry arrays: index 0 is s1, index 1 is s2.
  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [NB-1:0]         w_be    [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];
  logic [1:0]            w_cs;
  logic [1:0]            w_rd_req;
  logic [1:0]            w_wr_req;

  logic [1:0]            w_wr;
  logic [1:0]            w_rd;
  logic [1:0]            w_inr;
  logic [IDX_W-1:0]      w_idx   [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];

  logic                  r_vld   [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_dat   [2][READ_LATENCY];

  assign w_ce = clken & ~reset_req;

  assign w_addr[0]  = s1_address;
  assign w_addr[1]  = s2_address;
  assign w_be[0]    = s1_byteenable;
  assign w_be[1]    = s2_byteenable;
  assign w_wdata[0] = s1_writedata;
  assign w_wdata[1] = s2_writedata;
  assign w_cs       = {s2_chipselect, s1_chipselect};
  assign w_rd_req   = {s2_read, s1_read};
  assign w_wr_req   = {s2_write, s1_write};

  // Request decode and asynchronous array read (registered in stage 0).
  always_comb begin
    w_wr = '0;
    w_rd = '0;
    w_inr = '0;
    for (int p = 0; p < 2; p++) begin
      w_idx[p]   = w_addr[p][IDX_W-1:0];
      w_inr[p]   = ({1'b0, w_addr[p]} < LP_DEPTH);
      // Write has priority over read on the same port; requests seen while
      // reset is high are ignored.
      w_wr[p]    = w_cs[p] & w_wr_req[p] & w_ce & ~reset;
      w_rd[p]    = w_cs[p] & w_rd_req[p] & ~w_wr_req[p] & w_ce;
      w_rdata[p] = w_inr[p] ? r_mem[w_idx[p]] : '0;
    end
  end

  // Byte-lane writes. s2 is applied first and s1 second, so on a collision
  // the later non-blocking assignment from s1 wins on shared lanes.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (w_wr[p] && w_inr[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (w_be[p][b]) r_mem[w_idx[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline: shifts only when ce=1, so a stall freezes beats in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < READ_LATENCY; s++) begin
          r_vld[p][s] <= 1'b0;
          r_dat[p][s] <= '0;
        end
      end
    end else if (w_ce) begin
      for (int p = 0; p < 2; p++) begin
        r_vld[p][0] <= w_rd[p];
        r_dat[p][0] <= w_rdata[p];
        for (int s = 1; s < READ_LATENCY; s++) begin
          r_vld[p][s] <= r_vld[p][s-1];
          r_dat[p][s] <= r_dat[p][s-1];
        end
      end
    end
  end

  // A beat is only presented in a cycle where it also leaves the pipeline.
  assign s1_readdatavalid = r_vld[0][READ_LATENCY-1] & w_ce;
  assign s1_readdata      = r_dat[0][READ_LATENCY-1];
  assign s2_readdatavalid = r_vld[1][READ_LATENCY-1] & w_ce;
  assign s2_readdata      = r_dat[1][READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_onchip_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_avalon_onchip_ram_dp
//   Directed bench for avalon_onchip_ram_dp. Two instances share every input:
//   dut_a uses READ_LATENCY=1, dut_b uses READ_LATENCY=2. Inputs change 1 ns
//   after the rising edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_avalon_onchip_ram_dp;

  localparam int DW    = 32;
  localparam int DEPTH = 40;
  localparam int AW    = 16;

  logic          clk;
  logic          reset;
  logic          reset_req;
  logic          clken;

  logic [AW-1:0] s1_address;
  logic          s1_chipselect;
  logic          s1_read;
  logic          s1_write;
  logic [3:0]    s1_byteenable;
  logic [DW-1:0] s1_writedata;
  logic [AW-1:0] s2_address;
  logic          s2_chipselect;
  logic          s2_read;
  logic          s2_write;
  logic [3:0]    s2_byteenable;
  logic [DW-1:0] s2_writedata;

  logic [DW-1:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
  logic          a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv;

  logic [DW-1:0] mem_model [0:DEPTH-1];
  int            n_tests;
  int            n_fail;

  avalon_onchip_ram_dp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_FILE("")
  ) dut_a (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_rdv),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_rdv)
  );

  avalon_onchip_ram_dp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_FILE("")
  ) dut_b (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_rdv),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0;
    s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0;
    s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic drv_s1_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    s1_chipselect = 1; s1_write = 1; s1_read = 0;
    s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic drv_s2_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    s2_chipselect = 1; s2_write = 1; s2_read = 0;
    s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  task automatic drv_s1_rd(input logic [AW-1:0] a);
    s1_chipselect = 1; s1_read = 1; s1_write = 0; s1_address = a;
  endtask

  task automatic drv_s2_rd(input logic [AW-1:0] a);
    s2_chipselect = 1; s2_read = 1; s2_write = 0; s2_address = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; reset_req = 0; clken = 1;
    idle();
    repeat (3) next_cyc();
    @(negedge clk);
    n_tests++;
    if ({a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_valid: got %b expected 0000", {a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv});
    end
    n_tests++;
    if ({a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h expected 0",
               {a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata});
    end
    next_cyc();
    reset = 0;
  endtask

  task automatic test_cross_port_read();
    next_cyc(); idle(); drv_s1_wr(16'd5, 32'hDEADBEEF, 4'hF);
    next_cyc(); idle(); drv_s2_rd(16'd5);
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b0) begin
      n_fail++; $display("FAIL t1_early_valid: got %b expected 0", a_s2_rdv);
    end
    next_cyc(); idle();
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b1 || a_s2_readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL t1_read: got v=%b d=%h expected v=1 d=deadbeef", a_s2_rdv, a_s2_readdata);
    end
    next_cyc();
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b0) begin
      n_fail++; $display("FAIL t1_single_beat: got %b expected 0", a_s2_rdv);
    end
    mem_model[5] = 32'hDEADBEEF;
  endtask

  task automatic test_write_collision();
    next_cyc(); idle(); drv_s1_wr(16'd9, 32'h0, 4'hF);
    next_cyc(); idle();
    drv_s1_wr(16'd9, 32'h11223344, 4'b0011);
    drv_s2_wr(16'd9, 32'hAABBCCDD, 4'b0110);
    next_cyc(); idle(); drv_s1_rd(16'd9);
    next_cyc(); idle();
    @(negedge clk);
    n_tests++;
    if (a_s1_rdv !== 1'b1 || a_s1_readdata !== 32'h00BB3344) begin
      n_fail++;
      $display("FAIL t2_collision: got v=%b d=%h expected v=1 d=00bb3344", a_s1_rdv, a_s1_readdata);
    end
    mem_model[9] = 32'h00BB3344;
  endtask

  task automatic test_read_during_write();
    next_cyc(); idle(); drv_s1_wr(16'd7, 32'h1, 4'hF);
    next_cyc(); idle(); drv_s1_wr(16'd7, 32'h2, 4'hF); drv_s2_rd(16'd7);
    next_cyc(); idle(); drv_s2_rd(16'd7);
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b1 || a_s2_readdata !== 32'h1) begin
      n_fail++;
      $display("FAIL t3_old_data: got v=%b d=%h expected v=1 d=00000001", a_s2_rdv, a_s2_readdata);
    end
    next_cyc(); idle();
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b1 || a_s2_readdata !== 32'h2) begin
      n_fail++;
      $display("FAIL t3_new_data: got v=%b d=%h expected v=1 d=00000002", a_s2_rdv, a_s2_readdata);
    end
    mem_model[7] = 32'h2;
  endtask

  task automatic test_back_to_back_lat2();
    logic [DW-1:0] want;
    logic          exp_v;
    int            beats;
    for (int k = 0; k < 4; k++) begin
      next_cyc(); idle(); drv_s1_wr(AW'(k), 32'hA0 + k, 4'hF);
      mem_model[k] = 32'hA0 + k;
    end
    beats = 0;
    // Reads in cycles 0,1,5,6; clken low in cycles 2..4. Beats leave at 5..8.
    for (int c = 0; c < 12; c++) begin
      next_cyc(); idle();
      clken = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      if (c == 0) drv_s1_rd(16'd0);
      if (c == 1) drv_s1_rd(16'd1);
      if (c == 5) drv_s1_rd(16'd2);
      if (c == 6) drv_s1_rd(16'd3);
      @(negedge clk);
      exp_v = (c >= 5 && c <= 8);
      n_tests++;
      if (b_s1_rdv !== exp_v) begin
        n_fail++; $display("FAIL t4_valid_c%0d: got %b expected %b", c, b_s1_rdv, exp_v);
      end
      if (b_s1_rdv === 1'b1) begin
        want = 32'hA0 + beats;
        n_tests++;
        if (b_s1_readdata !== want) begin
          n_fail++; $display("FAIL t4_order_beat%0d: got %h expected %h", beats, b_s1_readdata, want);
        end
        beats++;
      end
    end
    clken = 1;
    n_tests++;
    if (beats != 4) begin
      n_fail++; $display("FAIL t4_beat_count: got %0d expected 4", beats);
    end
  endtask

  task automatic test_stall();
    next_cyc(); idle(); drv_s1_rd(16'd2);
    next_cyc(); idle(); reset_req = 1; drv_s1_wr(16'd2, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    n_tests++;
    if (a_s1_rdv !== 1'b0) begin
      n_fail++; $display("FAIL stall_gate1: got %b expected 0", a_s1_rdv);
    end
    next_cyc();
    @(negedge clk);
    n_tests++;
    if (a_s1_rdv !== 1'b0) begin
      n_fail++; $display("FAIL stall_gate2: got %b expected 0", a_s1_rdv);
    end
    next_cyc(); idle(); reset_req = 0;
    @(negedge clk);
    n_tests++;
    if (a_s1_rdv !== 1'b1 || a_s1_readdata !== 32'hA2) begin
      n_fail++;
      $display("FAIL stall_resume: got v=%b d=%h expected v=1 d=000000a2", a_s1_rdv, a_s1_readdata);
    end
    next_cyc(); idle(); drv_s1_rd(16'd2);
    @(negedge clk);
    n_tests++;
    if (a_s1_rdv !== 1'b0) begin
      n_fail++; $display("FAIL stall_no_dup: got %b expected 0", a_s1_rdv);
    end
    next_cyc(); idle();
    @(negedge clk);
    n_tests++;
    if (a_s1_readdata !== 32'hA2) begin
      n_fail++; $display("FAIL stall_write_dropped: got %h expected 000000a2", a_s1_readdata);
    end
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] oor [3];
    oor[0] = AW'(DEPTH); oor[1] = 16'hFFFF; oor[2] = 16'd69;  // 69 aliases word 5 in low bits
    next_cyc(); idle(); drv_s1_rd(oor[0]);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); idle();
      if (i < 2) drv_s1_rd(oor[i+1]);
      @(negedge clk);
      n_tests++;
      if (a_s1_rdv !== 1'b1 || a_s1_readdata !== 32'h0) begin
        n_fail++;
        $display("FAIL t5_oor_read_%h: got v=%b d=%h expected v=1 d=0", oor[i], a_s1_rdv, a_s1_readdata);
      end
    end
    next_cyc(); idle();
    drv_s1_wr(AW'(DEPTH), 32'h12345678, 4'hF);
    drv_s2_wr(16'd73, 32'hCAFEF00D, 4'hF);  // 73 aliases word 9 in low bits
    for (int a = 0; a < DEPTH; a++) begin
      next_cyc(); idle(); drv_s1_rd(AW'(a));
      next_cyc(); idle();
      @(negedge clk);
      n_tests++;
      if (a_s1_rdv !== 1'b1 || a_s1_readdata !== mem_model[a]) begin
        n_fail++;
        $display("FAIL t5_mem_%0d: got v=%b d=%h expected v=1 d=%h", a, a_s1_rdv, a_s1_readdata, mem_model[a]);
      end
    end
  endtask

  task automatic test_reset_flush();
    next_cyc(); idle(); drv_s1_rd(16'd5);
    next_cyc(); idle(); drv_s1_rd(16'd7);
    next_cyc(); idle(); reset = 1;
    drv_s1_wr(16'd1, 32'hFFFFFFFF, 4'hF); drv_s2_rd(16'd9);
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      if (c == 1) begin reset = 0; idle(); end
      @(negedge clk);
      n_tests++;
      if ({a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv} !== 4'b0000) begin
        n_fail++;
        $display("FAIL t6_flush_c%0d: got %b expected 0000", c, {a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv});
      end
      if (c == 0) begin
        n_tests++;
        if ({a_s1_readdata, b_s1_readdata} !== 64'h0) begin
          n_fail++; $display("FAIL t6_data_zero: got %h expected 0", {a_s1_readdata, b_s1_readdata});
        end
      end
    end
    next_cyc(); idle(); drv_s2_rd(16'd1);
    next_cyc(); idle(); drv_s2_rd(16'd5);
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b1 || a_s2_readdata !== 32'hA1) begin
      n_fail++;
      $display("FAIL t6_keep_1: got v=%b d=%h expected v=1 d=000000a1", a_s2_rdv, a_s2_readdata);
    end
    next_cyc(); idle();
    @(negedge clk);
    n_tests++;
    if (a_s2_rdv !== 1'b1 || a_s2_readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL t6_keep_5: got v=%b d=%h expected v=1 d=deadbeef", a_s2_rdv, a_s2_readdata);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    test_reset();
    test_cross_port_read();
    test_write_collision();
    test_read_during_write();
    test_back_to_back_lat2();
    test_stall();
    test_out_of_range();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
